// File: rtl/mem_arbiter_if.sv
// Core-side request/response and RAM-side bus shared by mem_arbiter.
// The slave modport is the arbiter; the master modport is the core plus RAM.
interface mem_arbiter_if #(
  parameter int WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              halt;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              err;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  halt, ramload, ramstate,
    output iwait, iload,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore,
    output err
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output halt, ramload, ramstate,
    input  iwait, iload,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter: instruction vs data requester, with
// anti-starvation, per-access timeout and halt parking.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [WORD_W-1:0] ZERO = '0;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    IGNT,
    DGNT,
    IACK,
    DACK,
    HALTED
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;

  logic dreq;
  logic force_i;
  logic access;
  logic expire;
  logic go_d;
  logic go_i;

  assign dreq    = bus.dREN | bus.dWEN;
  assign force_i = bus.iREN && (starve_cnt == SMAX);
  assign access  = bus.ramstate == RS_ACCESS;
  assign expire  = tcnt == TLAST;

  // halt outranks both requesters; data wins unless instruction is starving
  always_comb begin
    go_d = 1'b0;
    go_i = 1'b0;
    if (!bus.halt) begin
      go_d = dreq && !force_i;
      go_i = !go_d && bus.iREN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      tcnt         <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= ZERO;
      bus.ramstore <= ZERO;
      bus.iwait    <= 1'b1;
      bus.dwait    <= 1'b1;
      bus.iload    <= ZERO;
      bus.dload    <= ZERO;
      bus.err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            bus.halt: begin
              state <= HALTED;
            end
            go_d: begin
              state        <= DGNT;
              tcnt         <= '0;
              bus.ramWEN   <= bus.dWEN;
              bus.ramREN   <= ~bus.dWEN;
              bus.ramaddr  <= bus.daddr;
              bus.ramstore <= bus.dWEN ? bus.dstore : ZERO;
              if (bus.iREN && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + SW'(1);
            end
            go_i: begin
              state        <= IGNT;
              tcnt         <= '0;
              starve_cnt   <= '0;
              bus.ramREN   <= 1'b1;
              bus.ramWEN   <= 1'b0;
              bus.ramaddr  <= bus.iaddr;
              bus.ramstore <= ZERO;
            end
            default: ;
          endcase
        end

        IGNT, DGNT: begin
          // ACCESS beats an expiring counter in the same cycle
          if (access || expire) begin
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.ramaddr  <= ZERO;
            bus.ramstore <= ZERO;
            if (!access)
              bus.err <= 1'b1;
            if (state == IGNT) begin
              state     <= IACK;
              bus.iwait <= ~bus.iREN;
              bus.iload <= access ? bus.ramload : ZERO;
            end else begin
              state     <= DACK;
              bus.dwait <= ~dreq;
              if (!access)
                bus.dload <= ZERO;
              else if (bus.ramREN)
                bus.dload <= bus.ramload;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        IACK, DACK: begin
          state     <= IDLE;
          bus.iwait <= 1'b1;
          bus.dwait <= 1'b1;
        end

        HALTED: begin
          state <= HALTED;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
